// File: rtl/qam16_mixer.sv
// 16-QAM symbol mapper and carrier mixer. Buffers one symbol ahead, holds each
// symbol for SPS carrier samples, and emits (I*cos - Q*sin) >>> 3.
module qam16_mixer #(
    parameter int SPS = 16,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sym_valid,
    input  logic [3:0]    sym_data,
    output logic          sym_ready,
    output logic          carrier_en,
    input  logic [CW-1:0] carrier_sin,
    input  logic [CW-1:0] carrier_cos,
    output logic [15:0]   mod_out,
    output logic          mod_valid,
    output logic          underrun
);

    localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  sample_cnt;
    logic [3:0]        next_data;
    logic              next_full;
    logic signed [2:0] cur_i;
    logic signed [2:0] cur_q;
    logic signed [2:0] i_d1;
    logic signed [2:0] q_d1;
    logic              v1;
    logic              v2;
    logic              at_last;
    logic              consume;
    logic              accept;

    logic signed [CW+2:0] i_ext;
    logic signed [CW+2:0] q_ext;
    logic signed [CW+2:0] cos_ext;
    logic signed [CW+2:0] sin_ext;
    logic signed [CW+2:0] p_i;
    logic signed [CW+2:0] p_q;
    logic signed [CW+3:0] diff;
    logic signed [15:0]   scaled;

    // Gray code: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3
    function automatic logic signed [2:0] gray_level(input logic [1:0] bits);
        case (bits)
            2'b00:   gray_level = 3'b101;
            2'b01:   gray_level = 3'b111;
            2'b11:   gray_level = 3'b001;
            default: gray_level = 3'b011;
        endcase
    endfunction

    assign at_last    = (state == RUN) && (sample_cnt == LAST);
    assign consume    = next_full && ((state == IDLE) || at_last);
    assign sym_ready  = !rst && (!next_full || consume);
    assign accept     = sym_valid && sym_ready;
    assign carrier_en = !rst && (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            next_full <= 1'b0;
            next_data <= '0;
        end else if (accept) begin
            next_data <= sym_data;
            next_full <= 1'b1;
        end else if (consume) begin
            next_full <= 1'b0;
        end
    end

    // A symbol arriving on the boundary cycle lands in next_data too late to be seen here
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            underrun   <= 1'b0;
            cur_i      <= '0;
            cur_q      <= '0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (next_full) begin
                        state      <= RUN;
                        sample_cnt <= '0;
                    end
                end
                RUN: begin
                    if (at_last) begin
                        sample_cnt <= '0;
                        if (!next_full) begin
                            state    <= IDLE;
                            underrun <= 1'b1;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (consume) begin
                cur_i <= gray_level(next_data[3:2]);
                cur_q <= gray_level(next_data[1:0]);
            end
        end
    end

    assign i_ext   = {{CW{i_d1[2]}}, i_d1};
    assign q_ext   = {{CW{q_d1[2]}}, q_d1};
    assign cos_ext = {{3{carrier_cos[CW-1]}}, carrier_cos};
    assign sin_ext = {{3{carrier_sin[CW-1]}}, carrier_sin};
    assign diff    = {p_i[CW+2], p_i} - {p_q[CW+2], p_q};
    assign scaled  = 16'(diff >>> 3);

    // Levels are delayed one cycle so they meet the LUT sample they were enabled with
    always_ff @(posedge clk) begin
        if (rst) begin
            i_d1      <= '0;
            q_d1      <= '0;
            v1        <= 1'b0;
            p_i       <= '0;
            p_q       <= '0;
            v2        <= 1'b0;
            mod_out   <= '0;
            mod_valid <= 1'b0;
        end else begin
            i_d1 <= cur_i;
            q_d1 <= cur_q;
            v1   <= carrier_en;
            p_i  <= i_ext * cos_ext;
            p_q  <= q_ext * sin_ext;
            v2   <= v1;
            if (v2) begin
                mod_out   <= scaled;
                mod_valid <= 1'b1;
            end else begin
                mod_out   <= '0;
                mod_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qam16_mixer.sv
// Self-checking bench for qam16_mixer: a registered sin/cos LUT stand-in feeds the
// DUT, and expected samples come from a symbol-list reference model.
module tb_qam16_mixer;

    localparam int SPS = 16;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          sym_valid;
    logic [3:0]    sym_data;
    logic          sym_ready;
    logic          carrier_en;
    logic [CW-1:0] carrier_sin = '0;
    logic [CW-1:0] carrier_cos = '0;
    logic [15:0]   mod_out;
    logic          mod_valid;
    logic          underrun;

    always #5 clk = ~clk;

    qam16_mixer #(.SPS(SPS), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .sym_valid(sym_valid),
        .sym_data(sym_data),
        .sym_ready(sym_ready),
        .carrier_en(carrier_en),
        .carrier_sin(carrier_sin),
        .carrier_cos(carrier_cos),
        .mod_out(mod_out),
        .mod_valid(mod_valid),
        .underrun(underrun)
    );

    int cos_tab[64];
    int sin_tab[64];
    int lut_phase = 0;
    bit lut_mode = 1'b0;
    int stub_cos = 0;
    int stub_sin = 0;

    // LUT stand-in: registered, advances only on enable, never reset by the DUT
    always @(posedge clk) begin
        if (carrier_en) begin
            if (lut_mode) begin
                carrier_cos <= 16'(cos_tab[lut_phase % 64]);
                carrier_sin <= 16'(sin_tab[lut_phase % 64]);
            end else begin
                carrier_cos <= 16'(stub_cos);
                carrier_sin <= 16'(stub_sin);
            end
            lut_phase <= lut_phase + 1;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    logic       obs_en[$];
    logic       obs_mv[$];
    logic       obs_ur[$];
    int         obs_mo[$];
    int         mv_q[$];
    int         exp_q[$];
    logic [3:0] acc_q[$];
    bit         acc_flag;
    int         stalls;

    int n_en, first_en, last_en, n_mv, first_mv, last_mv, n_ur, first_ur, nz_idle;

    function automatic int level(input logic [1:0] b);
        case (b)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int div8_floor(input int v);
        if (v >= 0) return v / 8;
        return -((-v + 7) / 8);
    endfunction

    // Every accepted symbol owns the next SPS LUT samples, in acceptance order
    function automatic void build_expected(input int phase0);
        int n = 0;
        exp_q.delete();
        foreach (acc_q[k]) begin
            int iv;
            int qv;
            logic [3:0] s;
            s  = acc_q[k];
            iv = level(s[3:2]);
            qv = level(s[1:0]);
            for (int j = 0; j < SPS; j++) begin
                int c;
                int sn;
                c  = lut_mode ? cos_tab[(phase0 + n) % 64] : stub_cos;
                sn = lut_mode ? sin_tab[(phase0 + n) % 64] : stub_sin;
                exp_q.push_back(div8_floor(iv * c - qv * sn));
                n++;
            end
        end
    endfunction

    task automatic step(input logic v, input logic [3:0] d, input logic r);
        @(negedge clk);
        rst       = r;
        sym_valid = v;
        sym_data  = v ? d : 4'bxxxx;
        #1;
        acc_flag = v && sym_ready;
        if (acc_flag) acc_q.push_back(d);
        if (v && !sym_ready) stalls++;
        obs_en.push_back(carrier_en);
        obs_mv.push_back(mod_valid);
        obs_ur.push_back(underrun);
        obs_mo.push_back(int'($signed(mod_out)));
    endtask

    task automatic clear_obs();
        obs_en.delete();
        obs_mv.delete();
        obs_ur.delete();
        obs_mo.delete();
        acc_q.delete();
        stalls = 0;
    endtask

    task automatic send(input logic [3:0] d, output bit ok);
        int guard = 0;
        ok = 1'b0;
        while (!ok && guard < 200) begin
            step(1'b1, d, 1'b0);
            ok = acc_flag;
            guard++;
        end
    endtask

    task automatic analyze();
        n_en = 0; first_en = -1; last_en = -1;
        n_mv = 0; first_mv = -1; last_mv = -1;
        n_ur = 0; first_ur = -1; nz_idle = 0;
        mv_q.delete();
        foreach (obs_en[i]) begin
            if (obs_en[i]) begin
                n_en++;
                if (first_en < 0) first_en = i;
                last_en = i;
            end
            if (obs_mv[i]) begin
                n_mv++;
                if (first_mv < 0) first_mv = i;
                last_mv = i;
                mv_q.push_back(obs_mo[i]);
            end else if (obs_mo[i] != 0) begin
                nz_idle++;
            end
            if (obs_ur[i]) begin
                n_ur++;
                if (first_ur < 0) first_ur = i;
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, 4'h0, 1'b1);
        vectors++;
        if (carrier_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_en_in_rst: got %b want 0", carrier_en);
        end
        vectors++;
        if (sym_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_in_rst: got %b want 0", sym_ready);
        end
        step(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 4'h0, 1'b0);
            vectors++;
            if (carrier_en !== 1'b0 || mod_valid !== 1'b0 || mod_out !== 16'h0 ||
                underrun !== 1'b0 || sym_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: en=%b mv=%b out=%h ur=%b rdy=%b want 0,0,0000,0,1",
                         i, carrier_en, mod_valid, mod_out, underrun, sym_ready);
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        lut_mode = 1'b0;
        stub_cos = 32767;
        stub_sin = 0;
        clear_obs();
        send(4'b1010, ok);
        for (int i = 0; i < 40; i++) step(1'b0, 4'h0, 1'b0);
        analyze();
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_accept: symbol not accepted within bound");
        end
        vectors++;
        if (n_en != 16) begin
            miscompares++;
            $display("FAIL single_en_count: got %0d want 16", n_en);
        end
        vectors++;
        if (n_mv != 16) begin
            miscompares++;
            $display("FAIL single_mv_count: got %0d want 16", n_mv);
        end
        foreach (mv_q[i]) begin
            vectors++;
            if (mv_q[i] != 12287) begin
                miscompares++;
                $display("FAIL single_value[%0d]: got %0d want 12287", i, mv_q[i]);
            end
        end
        vectors++;
        if (first_mv - first_en != 3) begin
            miscompares++;
            $display("FAIL single_latency: got %0d want 3", first_mv - first_en);
        end
        vectors++;
        if (n_ur != 1 || first_ur != last_en + 1) begin
            miscompares++;
            $display("FAIL single_underrun: got count %0d at %0d want 1 at %0d", n_ur, first_ur, last_en + 1);
        end
        vectors++;
        if (nz_idle != 0) begin
            miscompares++;
            $display("FAIL single_idle_zero: got %0d nonzero idle samples want 0", nz_idle);
        end
    endtask

    task automatic test_floor();
        bit ok;
        int want[2];
        want[0] = -12288;
        want[1] = 12287;
        lut_mode = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            stub_cos = (pass == 0) ? 32767 : 0;
            stub_sin = (pass == 0) ? 0 : 32767;
            clear_obs();
            send(4'b0000, ok);
            for (int i = 0; i < 40; i++) step(1'b0, 4'h0, 1'b0);
            analyze();
            vectors++;
            if (n_mv != 16) begin
                miscompares++;
                $display("FAIL floor_count pass %0d: got %0d want 16", pass, n_mv);
            end
            foreach (mv_q[i]) begin
                vectors++;
                if (mv_q[i] != want[pass]) begin
                    miscompares++;
                    $display("FAIL floor_value pass %0d [%0d]: got %0d want %0d", pass, i, mv_q[i], want[pass]);
                end
            end
        end
    endtask

    task automatic test_stream();
        logic [3:0] syms[8];
        int sent = 0;
        int guard = 0;
        int phase0;
        int bad = 0;
        lut_mode = 1'b1;
        phase0 = lut_phase;
        clear_obs();
        foreach (syms[i]) syms[i] = 4'($urandom_range(15, 0));
        while (sent < 8 && guard < 400) begin
            step(1'b1, syms[sent], 1'b0);
            if (acc_flag) sent++;
            guard++;
        end
        for (int i = 0; i < 40; i++) step(1'b0, 4'h0, 1'b0);
        analyze();
        build_expected(phase0);
        vectors++;
        if (acc_q.size() != 8) begin
            miscompares++;
            $display("FAIL stream_accepted: got %0d want 8", acc_q.size());
        end
        for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
            vectors++;
            if (acc_q[i] !== syms[i]) begin
                miscompares++;
                $display("FAIL stream_order[%0d]: got %h want %h", i, acc_q[i], syms[i]);
            end
        end
        vectors++;
        if (n_en != 128 || last_en - first_en + 1 != 128) begin
            miscompares++;
            $display("FAIL stream_en: got %0d over span %0d want 128 contiguous", n_en, last_en - first_en + 1);
        end
        vectors++;
        if (n_mv != 128 || last_mv - first_mv + 1 != 128) begin
            miscompares++;
            $display("FAIL stream_mv: got %0d over span %0d want 128 contiguous", n_mv, last_mv - first_mv + 1);
        end
        vectors++;
        if (n_ur != 1 || first_ur != last_en + 1) begin
            miscompares++;
            $display("FAIL stream_underrun: got count %0d at %0d want 1 at %0d", n_ur, first_ur, last_en + 1);
        end
        for (int i = 3; i < obs_mv.size(); i++) if (obs_mv[i] !== obs_en[i-3]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stream_valid_delay: got %0d cycles where mod_valid != en delayed 3, want 0", bad);
        end
        vectors++;
        if (mv_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL stream_len: got %0d want %0d", mv_q.size(), exp_q.size());
        end
        for (int i = 0; i < mv_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (mv_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stream_value[%0d]: got %0d want %0d", i, mv_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] s[3];
        bit ok;
        int a;
        lut_mode = 1'b0;
        stub_cos = int'($urandom_range(65534, 0)) - 32767;
        stub_sin = int'($urandom_range(65534, 0)) - 32767;
        a    = int'($urandom_range(15, 0));
        s[0] = 4'(a);
        s[1] = 4'(a + 5);
        s[2] = 4'(a + 10);
        clear_obs();
        for (int k = 0; k < 3; k++) begin
            send(s[k], ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL bp_accept[%0d]: symbol not accepted within bound", k);
            end
        end
        for (int i = 0; i < 70; i++) step(1'b0, 4'h0, 1'b0);
        analyze();
        build_expected(0);
        vectors++;
        if (stalls == 0) begin
            miscompares++;
            $display("FAIL bp_stall: got 0 stalled cycles want >0");
        end
        vectors++;
        if (acc_q.size() != 3) begin
            miscompares++;
            $display("FAIL bp_count: got %0d want 3", acc_q.size());
        end
        for (int k = 0; k < 3 && k < acc_q.size(); k++) begin
            vectors++;
            if (acc_q[k] !== s[k]) begin
                miscompares++;
                $display("FAIL bp_order[%0d]: got %h want %h", k, acc_q[k], s[k]);
            end
        end
        vectors++;
        if (n_mv != 48 || n_ur != 1) begin
            miscompares++;
            $display("FAIL bp_totals: got mv %0d ur %0d want 48 and 1", n_mv, n_ur);
        end
        for (int i = 0; i < mv_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (mv_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bp_value[%0d]: got %0d want %0d", i, mv_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok_a, ok_b, ok_c;
        int en_seen = 0;
        int guard = 0;
        lut_mode = 1'b0;
        stub_cos = int'($urandom_range(65534, 0)) - 32767;
        stub_sin = int'($urandom_range(65534, 0)) - 32767;
        clear_obs();
        send(4'($urandom_range(15, 0)), ok_a);
        send(4'($urandom_range(15, 0)), ok_b);
        foreach (obs_en[i]) if (obs_en[i]) en_seen++;
        while (en_seen < 7 && guard < 60) begin
            step(1'b0, 4'h0, 1'b0);
            if (carrier_en) en_seen++;
            guard++;
        end
        vectors++;
        if (!ok_a || !ok_b || en_seen != 7 || sym_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_setup: got acc %b%b samples %0d rdy %b want 11, 7, 0", ok_a, ok_b, en_seen, sym_ready);
        end
        step(1'b0, 4'h0, 1'b1);
        vectors++;
        if (carrier_en !== 1'b0 || sym_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_during: got en %b rdy %b want 0 0", carrier_en, sym_ready);
        end
        step(1'b0, 4'h0, 1'b0);
        vectors++;
        if (carrier_en !== 1'b0 || mod_valid !== 1'b0 || underrun !== 1'b0 ||
            mod_out !== 16'h0 || sym_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_after: got en %b mv %b ur %b out %h rdy %b want 0 0 0 0000 1",
                     carrier_en, mod_valid, underrun, mod_out, sym_ready);
        end
        clear_obs();
        for (int i = 0; i < 40; i++) step(1'b0, 4'h0, 1'b0);
        analyze();
        vectors++;
        if (n_en != 0 || n_mv != 0 || n_ur != 0) begin
            miscompares++;
            $display("FAIL rmid_discard: got en %0d mv %0d ur %0d want 0 0 0", n_en, n_mv, n_ur);
        end
        clear_obs();
        send(4'($urandom_range(15, 0)), ok_c);
        for (int i = 0; i < 40; i++) step(1'b0, 4'h0, 1'b0);
        analyze();
        build_expected(0);
        vectors++;
        if (!ok_c || n_en != 16 || n_mv != 16 || n_ur != 1) begin
            miscompares++;
            $display("FAIL rmid_restart: got acc %b en %0d mv %0d ur %0d want 1 16 16 1", ok_c, n_en, n_mv, n_ur);
        end
        for (int i = 0; i < mv_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (mv_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rmid_value[%0d]: got %0d want %0d", i, mv_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_data  = 4'h0;
        for (int k = 0; k < 64; k++) begin
            cos_tab[k] = $rtoi(32767.0 * $cos(6.283185307179586 * k / 64.0));
            sin_tab[k] = $rtoi(32767.0 * $sin(6.283185307179586 * k / 64.0));
        end
        test_reset();
        test_single();
        test_floor();
        test_stream();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
